// File: rtl/sprite_rom_pkg.sv
// Shared sprite ROM constants and requester indices for the arbiter and ROM wrappers.
package sprite_rom_pkg;

  localparam int SPRITE_ADDR_W    = 13;
  localparam int SPRITE_DATA_W    = 8;
  localparam int SPRITE_ROM_DEPTH = 7470;
  localparam int SPRITE_NUM_REQ   = 4;

  typedef enum logic [1:0] {
    REQ_SCORE0 = 2'd0,
    REQ_SCORE1 = 2'd1,
    REQ_PIN    = 2'd2,
    REQ_BALL   = 2'd3
  } sprite_req_e;

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Request/grant/response bundle between the sprite drawing logic, the arbiter and the ROM.
interface sprite_rom_arbiter_if
  import sprite_rom_pkg::*;
#(
  parameter int NUM_REQ = SPRITE_NUM_REQ,
  parameter int ADDR_W  = SPRITE_ADDR_W,
  parameter int DATA_W  = SPRITE_DATA_W
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]         rom_addr;
  logic [DATA_W-1:0]         rom_data;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      oob_err;

  modport master (
    output req, req_addr, rom_data,
    input  gnt, rom_addr, rsp_valid, rsp_data, oob_err
  );

  modport slave (
    input  req, req_addr, rom_data,
    output gnt, rom_addr, rsp_valid, rsp_data, oob_err
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: last-granted pointer, rotated priority search, one-hot grant.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk_pix,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_gnt
);
  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] r_last;
  logic [PTR_W-1:0] w_next_last;
  logic [PTR_W:0]   w_idx;
  logic             w_found;
  logic [NUM_REQ-1:0] w_gnt;

  always_comb begin
    w_gnt       = '0;
    w_found     = 1'b0;
    w_next_last = r_last;
    w_idx       = '0;
    // Candidates are visited from last+1 onward, wrapping past NUM_REQ-1.
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = {1'b0, r_last} + (PTR_W+1)'(k);
      if (w_idx >= (PTR_W+1)'(NUM_REQ)) begin
        w_idx = w_idx - (PTR_W+1)'(NUM_REQ);
      end
      if (!w_found && i_req[w_idx[PTR_W-1:0]]) begin
        w_gnt[w_idx[PTR_W-1:0]] = 1'b1;
        w_found                 = 1'b1;
        w_next_last             = w_idx[PTR_W-1:0];
      end
    end
    if (!rst_n) begin
      w_gnt   = '0;
      w_found = 1'b0;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      r_last <= PTR_W'(NUM_REQ-1);
    end else if (w_found) begin
      r_last <= w_next_last;
    end
  end

  assign o_gnt = w_gnt;
endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one registered-read sprite ROM port among NUM_REQ requesters, returning data 2 cycles after grant.
// Optional bounds checking enabled by defining SPRITE_ARB_BOUNDS_CHK_EN.
module sprite_rom_arbiter
  import sprite_rom_pkg::*;
#(
  parameter int NUM_REQ   = SPRITE_NUM_REQ,
  parameter int ADDR_W    = SPRITE_ADDR_W,
  parameter int DATA_W    = SPRITE_DATA_W,
  parameter int ROM_DEPTH = SPRITE_ROM_DEPTH
) (
  input logic                 clk_pix,
  input logic                 rst_n,
  sprite_rom_arbiter_if.slave bus
);
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_any;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [ADDR_W-1:0]  w_eff_addr;
  logic [ADDR_W-1:0]  w_rom_addr;
  logic [ADDR_W-1:0]  r_addr_hold;
  logic [NUM_REQ-1:0] r_tag;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_data;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk_pix (clk_pix),
    .rst_n   (rst_n),
    .i_req   (bus.req),
    .o_gnt   (w_gnt)
  );

  assign w_any = |w_gnt;

  always_comb begin
    w_sel_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_addr = w_sel_addr | bus.req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

`ifdef SPRITE_ARB_BOUNDS_CHK_EN
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(ROM_DEPTH);

  logic w_oob;
  logic r_oob;
  logic r_oob_err;

  // Out-of-range grants are still accepted; they read entry 0 and return zero.
  assign w_oob      = w_any && ({1'b0, w_sel_addr} >= DEPTH_L);
  assign w_eff_addr = w_oob ? '0 : w_sel_addr;

  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      r_oob      <= 1'b0;
      r_oob_err  <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      r_oob <= w_oob;
      if (|r_tag) begin
        r_rsp_data <= r_oob ? '0 : bus.rom_data;
        r_oob_err  <= r_oob_err | r_oob;
      end
    end
  end

  assign bus.oob_err = r_oob_err;
`else
  assign w_eff_addr = w_sel_addr;

  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      r_rsp_data <= '0;
    end else if (|r_tag) begin
      r_rsp_data <= bus.rom_data;
    end
  end

  assign bus.oob_err = 1'b0;
`endif

  assign w_rom_addr = w_any ? w_eff_addr : r_addr_hold;

  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      r_addr_hold <= '0;
      r_tag       <= '0;
      r_rsp_valid <= '0;
    end else begin
      r_addr_hold <= w_rom_addr;
      r_tag       <= w_gnt;
      r_rsp_valid <= r_tag;
    end
  end

  assign bus.gnt       = w_gnt;
  assign bus.rom_addr  = w_rom_addr;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter: directed scenarios plus randomized requesters vs. a reference model.
module tb_sprite_rom_arbiter;
  localparam int N     = 4;
  localparam int AW    = 13;
  localparam int DW    = 8;
  localparam int DEPTH = 7470;
  localparam int INF   = 32'h7fff_ffff;
`ifdef SPRITE_ARB_BOUNDS_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [N-1:0]  tag;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic clk_pix = 1'b0;
  logic rst_n   = 1'b0;
  int   cyc     = 0;
  int   total   = 0;
  int   bad     = 0;

  logic [DW-1:0] rom_mem [0:(1<<AW)-1];
  exp_t          sbq [$];
  int            m_ptr;
  logic [AW-1:0] m_hold;
  logic [DW-1:0] m_last_data;
  int            oob_due;
  int            grant_cnt [N];

  sprite_rom_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_DEPTH(DEPTH)) dut (
    .clk_pix (clk_pix),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 clk_pix = ~clk_pix;
  always @(posedge clk_pix) cyc <= cyc + 1;

  // ROM model with one-cycle registered read
  always @(posedge clk_pix) bus.rom_data <= rom_mem[bus.rom_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // Drive one cycle of requests, check grant/address and predict the response.
  task automatic drive_cycle(input logic rstv, input logic [N-1:0] rq,
                             input logic [N*AW-1:0] ad, output int win);
    logic [N-1:0]  eg;
    logic [AW-1:0] a;
    logic [AW-1:0] exp_rom;
    logic          oob;
    exp_t          e;
    @(negedge clk_pix);
    rst_n        = rstv;
    bus.req      = rq;
    bus.req_addr = ad;
    #1;
    win = -1;
    if (!rstv) begin
      chk("gnt_in_reset", 32'(bus.gnt), 32'd0);
      m_ptr       = N - 1;
      m_hold      = '0;
      m_last_data = '0;
      oob_due     = INF;
      sbq.delete();
      return;
    end
    for (int k = 1; k <= N; k++) begin
      if (win < 0 && rq[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    end
    eg = '0;
    if (win >= 0) eg[win] = 1'b1;
    chk("gnt", 32'(bus.gnt), 32'(eg));
    if (win >= 0) begin
      a       = ad[win*AW +: AW];
      oob     = CHK && (int'(a) >= DEPTH);
      exp_rom = oob ? '0 : a;
      e.tag   = eg;
      e.data  = oob ? 8'h00 : rom_mem[a];
      e.due   = cyc + 2;
      sbq.push_back(e);
      if (oob && e.due < oob_due) oob_due = e.due;
      m_ptr = win;
      grant_cnt[win]++;
    end else begin
      exp_rom = m_hold;
    end
    chk("rom_addr", 32'(bus.rom_addr), 32'(exp_rom));
    m_hold = exp_rom;
  endtask

  // Monitor: compares presented responses against the scoreboard queue.
  initial begin
    forever begin
      @(negedge clk_pix);
      #3;
      if (bus.rsp_valid != '0) begin
        if (sbq.size() == 0 || sbq[0].due != cyc) begin
          chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
        end else begin
          chk("rsp_tag", 32'(bus.rsp_valid), 32'(sbq[0].tag));
          chk("rsp_data", 32'(bus.rsp_data), 32'(sbq[0].data));
          $display("rsp cyc=%0d tag=%b data=%02h", cyc, bus.rsp_valid, bus.rsp_data);
          m_last_data = sbq[0].data;
          void'(sbq.pop_front());
        end
      end else begin
        if (sbq.size() != 0 && sbq[0].due == cyc) begin
          chk("rsp_missing", 32'(bus.rsp_valid), 32'(sbq[0].tag));
          void'(sbq.pop_front());
        end
        if (rst_n) chk("rsp_data_hold", 32'(bus.rsp_data), 32'(m_last_data));
      end
      if (rst_n) chk("oob_err", 32'(bus.oob_err), 32'(cyc >= oob_due));
    end
  end

  initial begin
    logic [N*AW-1:0] ad;
    logic [N-1:0]    pend;
    logic [AW-1:0]   paddr [N];
    int              w;

    for (int a = 0; a < (1 << AW); a++) rom_mem[a] = 8'((a * 37) ^ (a >> 5) ^ 8'h3C);
    rom_mem[16]  = 8'hA5;
    bus.rom_data = '0;
    bus.req      = '0;
    bus.req_addr = '0;
    m_ptr = N - 1; m_hold = '0; m_last_data = '0; oob_due = INF;

    repeat (3) drive_cycle(1'b0, '0, '0, w);
    drive_cycle(1'b1, '0, '0, w);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("reset_oob_err", 32'(bus.oob_err), 32'd0);
    chk("reset_rom_addr", 32'(bus.rom_addr), 32'd0);

    // All requesting continuously: strict 0,1,2,3 rotation.
    for (int i = 0; i < N; i++) grant_cnt[i] = 0;
    for (int i = 0; i < N; i++) ad[i*AW +: AW] = AW'(100 * i + 7);
    for (int c = 0; c < 40; c++) begin
      drive_cycle(1'b1, '1, ad, w);
      chk("fair_order", 32'(w), 32'(c % N));
    end
    for (int i = 0; i < N; i++) chk("fair_cnt", 32'(grant_cnt[i]), 32'd10);
    repeat (3) drive_cycle(1'b1, '0, ad, w);

    // Single requester 2 at 0x0010 returns 0xA5.
    ad = '0;
    ad[2*AW +: AW] = 13'h0010;
    drive_cycle(1'b1, 4'b0100, ad, w);
    repeat (3) drive_cycle(1'b1, '0, ad, w);

    // Requester 1 absent: pointer 0 skips to 2.
    drive_cycle(1'b1, 4'b0001, ad, w);
    drive_cycle(1'b1, 4'b0101, ad, w);
    chk("skip_dropped", 32'(w), 32'd2);

    repeat (10) drive_cycle(1'b1, '0, ad, w);

    // Out-of-range address at the boundary.
    ad = '0;
    ad[0 +: AW] = AW'(DEPTH);
    drive_cycle(1'b1, 4'b0001, ad, w);
    repeat (4) drive_cycle(1'b1, '0, ad, w);

    // Reset in the cycle after an accept flushes the pipeline.
    ad = '0;
    ad[0 +: AW] = 13'h0123;
    drive_cycle(1'b1, 4'b0001, ad, w);
    repeat (2) drive_cycle(1'b0, '1, ad, w);
    drive_cycle(1'b1, '1, ad, w);
    chk("post_reset_grant", 32'(w), 32'd0);
    repeat (3) drive_cycle(1'b1, '0, ad, w);

    // Randomized requesters that hold until granted and occasionally withdraw.
    pend = '0;
    for (int i = 0; i < N; i++) paddr[i] = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(9) < 4) begin
            pend[i]  = 1'b1;
            paddr[i] = ($urandom_range(9) == 0) ? AW'($urandom_range((1 << AW) - 1, DEPTH))
                                                : AW'($urandom_range(DEPTH - 1));
          end
        end else if ($urandom_range(19) == 0) begin
          pend[i] = 1'b0;
        end
        ad[i*AW +: AW] = paddr[i];
      end
      drive_cycle(1'b1, pend, ad, w);
      if (w >= 0) pend[w] = 1'b0;
    end
    repeat (4) drive_cycle(1'b1, '0, ad, w);
    chk("queue_drained", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
